mem_access_stage: RTL and testbench

//  Memory stage directly downstream of the execute stage. Latches the execute results
//  (ALU result, store data, branch target, zero flag) and their controls.

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_access_stage_timeout.sv | 37 +++
 rtl/mem_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
//   mem_state_t      : controller state encoding (IDLE / BUSY)
//   DEFAULT_TIMEOUT  : default number of BUSY cycles allowed before an access is aborted
//   DEFAULT_WIDTH    : default datapath width (address, data, PC)
package mem_stage_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mem_state_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_WIDTH   = 64;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Wait counter for the data-memory handshake.
// Counts enabled cycles up from zero; expired is raised while enabled and on the
// last allowed cycle (count == TIMEOUT-1). The count saturates there, so it never wraps.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-low reset
//   clear   in  restart the count at zero (wins over enable)
//   enable  in  count this cycle (memory stage busy)
//   expired out last allowed cycle reached while enabled
module timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    assign expired = enable && (wait_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && (wait_cnt != LAST)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage following execute. Latches execute results, resolves the CBZ branch
// decision and runs loads/stores over a req/ack data-memory handshake, stalling
// upstream while an access is outstanding and aborting it after TIMEOUT BUSY cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no memory access outstanding; any op may be accepted
//   BUSY  | dm_req high, waiting for dm_ack (or for the timeout to expire)
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   valid_E .. zero_E          execute-stage results and controls
//   stall_M                    upstream must hold *_E stable
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_rdata/dm_ack   data-memory handshake
//   valid_M .. mem_err_M       registered stage results (valid_M is a 1-cycle pulse)
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int N       = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    output logic         stall_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic [N-1:0] dm_rdata,
    input  logic         dm_ack,
    output logic         valid_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic         mem_err_M
);

    mem_state_t   state, state_nxt;

    logic         busy;
    logic         accept;
    logic         mem_op_E;
    logic         ack_done;
    logic         abort;
    logic         expired;
    logic         alu_pend;
    logic         slot_taken;

    logic         lat_read, lat_write, lat_branch, lat_zero;
    logic [N-1:0] lat_alu, lat_wdata, lat_pcb;

    assign busy       = (state == S_BUSY);
    assign stall_M    = busy && !dm_ack;
    assign accept     = valid_E && !stall_M;
    assign mem_op_E   = MemRead_E || MemWrite_E;
    assign ack_done   = busy && dm_ack;
    assign abort      = busy && !dm_ack && expired;
    // The output registers are already claimed this edge by a completing access
    // or by a deferred ALU op.
    assign slot_taken = ack_done || alu_pend;

    assign dm_req   = busy;
    assign dm_we    = busy && lat_write;
    assign dm_addr  = busy ? lat_alu   : '0;
    assign dm_wdata = busy ? lat_wdata : '0;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept && mem_op_E),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && mem_op_E) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dm_ack) begin
                    state_nxt = (accept && mem_op_E) ? S_BUSY : S_IDLE;
                end else if (expired) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_branch <= 1'b0;
            lat_zero   <= 1'b0;
            lat_alu    <= '0;
            lat_wdata  <= '0;
            lat_pcb    <= '0;
        end else if (accept) begin
            lat_read   <= MemRead_E;
            lat_write  <= MemWrite_E;
            lat_branch <= Branch_E;
            lat_zero   <= zero_E;
            lat_alu    <= aluResult_E;
            lat_wdata  <= writeData_E;
            lat_pcb    <= PCBranch_E;
        end
    end

    // A non-memory op accepted on an edge whose output slot is taken is held in
    // the latch and reported one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_pend <= 1'b0;
        end else begin
            alu_pend <= accept && !mem_op_E && slot_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_M     <= 1'b0;
            mem_err_M   <= 1'b0;
            PCSrc_M     <= 1'b0;
            aluResult_M <= '0;
            readData_M  <= '0;
            PCBranch_M  <= '0;
        end else begin
            valid_M   <= 1'b0;
            mem_err_M <= 1'b0;
            PCSrc_M   <= 1'b0;
            if (ack_done || abort) begin
                valid_M     <= 1'b1;
                mem_err_M   <= abort;
                PCSrc_M     <= lat_branch && lat_zero;
                aluResult_M <= lat_alu;
                PCBranch_M  <= lat_pcb;
                // Stores win over a simultaneous read request and return no data.
                readData_M  <= (ack_done && lat_read && !lat_write) ? dm_rdata : '0;
            end else if (alu_pend) begin
                valid_M     <= 1'b1;
                PCSrc_M     <= lat_branch && lat_zero;
                aluResult_M <= lat_alu;
                PCBranch_M  <= lat_pcb;
                readData_M  <= '0;
            end else if (accept && !mem_op_E) begin
                valid_M     <= 1'b1;
                PCSrc_M     <= Branch_E && zero_E;
                aluResult_M <= aluResult_E;
                PCBranch_M  <= PCBranch_E;
                readData_M  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int N   = 64;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_E, MemRead_E, MemWrite_E, Branch_E, zero_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         stall_M, dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic [N-1:0] dm_rdata = '0;
    logic         dm_ack = 1'b0;
    logic         valid_M, PCSrc_M, mem_err_M;
    logic [N-1:0] aluResult_M, readData_M, PCBranch_M;

    always #5 clk = ~clk;

    mem_access_stage #(.N(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .valid_E     (valid_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .Branch_E    (Branch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .zero_E      (zero_E),
        .stall_M     (stall_M),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack),
        .valid_M     (valid_M),
        .aluResult_M (aluResult_M),
        .readData_M  (readData_M),
        .PCBranch_M  (PCBranch_M),
        .PCSrc_M     (PCSrc_M),
        .mem_err_M   (mem_err_M)
    );

    typedef struct {
        logic [63:0] alu;
        logic [63:0] rd;
        logic [63:0] pcb;
        logic        pcsrc;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    exp_t        sb[$];
    req_t        rq[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          stall_cnt = 0, req_cnt = 0, req_rises = 0, valid_cnt = 0;
    int          b_stall, b_req, b_rise, b_valid;
    logic        req_q = 1'b0;
    int          ack_at = 0;
    logic        ack_rand = 1'b1;
    logic [63:0] rdata_val = '0;
    int          busy_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks the ack_at-th cycle of each request (0 = never).
    always begin
        @(posedge clk);
        #1;
        if (ack_rand) begin
            dm_ack   = 1'($urandom);
            dm_rdata = {$urandom, $urandom};
        end else if (dm_req) begin
            busy_cyc++;
            if (busy_cyc == 1) begin
                if (rq.size() == 0) begin
                    check("req_unexpected", 64'd1, 64'd0);
                end else begin
                    req_t r;
                    r = rq.pop_front();
                    check("dm_we", {63'b0, dm_we}, {63'b0, r.we});
                    check("dm_addr", dm_addr, r.addr);
                    if (r.we) check("dm_wdata", dm_wdata, r.wdata);
                end
            end
            if (ack_at != 0 && busy_cyc == ack_at) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata_val;
                busy_cyc = 0;
            end else begin
                dm_ack   = 1'b0;
                dm_rdata = {$urandom, $urandom};
            end
        end else begin
            busy_cyc = 0;
            dm_ack   = 1'b0;
        end
    end

    // Output monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_M) stall_cnt++;
            if (dm_req) req_cnt++;
            if (dm_req && !req_q) req_rises++;
            req_q = dm_req;
            if (valid_M) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("valid_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("aluResult_M", aluResult_M, e.alu);
                    check("readData_M", readData_M, e.rd);
                    check("PCBranch_M", PCBranch_M, e.pcb);
                    check("PCSrc_M", {63'b0, PCSrc_M}, {63'b0, e.pcsrc});
                    check("mem_err_M", {63'b0, mem_err_M}, {63'b0, e.err});
                end
            end else begin
                check("stray_pulse", {62'b0, mem_err_M, PCSrc_M}, 64'd0);
            end
        end else begin
            req_q = 1'b0;
        end
    end

    task automatic snap();
        b_stall = stall_cnt;
        b_req   = req_cnt;
        b_rise  = req_rises;
        b_valid = valid_cnt;
    endtask

    task automatic idle_inputs();
        valid_E     = 1'b0;
        MemRead_E   = 1'b0;
        MemWrite_E  = 1'b0;
        Branch_E    = 1'b0;
        zero_E      = 1'b0;
        aluResult_E = {$urandom, $urandom};
        writeData_E = {$urandom, $urandom};
        PCBranch_E  = {$urandom, $urandom};
    endtask

    // Called at posedge+2; returns at posedge+2 right after the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic br, input logic zr,
                         input logic [63:0] alu, input logic [63:0] wd,
                         input logic [63:0] pcb, input logic err_exp);
        exp_t e;
        req_t r;
        bit   ok = 1'b0;
        valid_E     = 1'b1;
        MemRead_E   = rd;
        MemWrite_E  = wr;
        Branch_E    = br;
        zero_E      = zr;
        aluResult_E = alu;
        writeData_E = wd;
        PCBranch_E  = pcb;
        e.alu   = alu;
        e.pcb   = pcb;
        e.pcsrc = br & zr;
        e.err   = err_exp;
        e.rd    = (rd && !wr && !err_exp) ? rdata_val : 64'd0;
        sb.push_back(e);
        if (rd || wr) begin
            r.we    = wr;
            r.addr  = alu;
            r.wdata = wd;
            rq.push_back(r);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_M) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", {63'b0, ok}, 64'd1);
        @(posedge clk);
        #2;
        idle_inputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (4) begin
            @(posedge clk);
            #2;
            valid_E     = 1'($urandom);
            MemRead_E   = 1'($urandom);
            MemWrite_E  = 1'($urandom);
            Branch_E    = 1'($urandom);
            zero_E      = 1'($urandom);
            aluResult_E = {$urandom, $urandom};
            writeData_E = {$urandom, $urandom};
            PCBranch_E  = {$urandom, $urandom};
        end
        @(negedge clk);
        check("rst_stall", {63'b0, stall_M}, 64'd0);
        check("rst_dm_req", {63'b0, dm_req}, 64'd0);
        check("rst_dm_we", {63'b0, dm_we}, 64'd0);
        check("rst_dm_addr", dm_addr, 64'd0);
        check("rst_dm_wdata", dm_wdata, 64'd0);
        check("rst_valid", {63'b0, valid_M}, 64'd0);
        check("rst_alu", aluResult_M, 64'd0);
        check("rst_rdata", readData_M, 64'd0);
        check("rst_pcb", PCBranch_M, 64'd0);
        check("rst_pcsrc", {63'b0, PCSrc_M}, 64'd0);
        check("rst_err", {63'b0, mem_err_M}, 64'd0);
        check("rst_state", {63'b0, dut.state}, {63'b0, S_IDLE});
        ack_rand = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // ALU op with taken branch: latency 1, never stalls
        snap();
        issue(1'b0, 1'b0, 1'b1, 1'b1, 64'h10, 64'h0, 64'h40, 1'b0);
        check("alu_latency", {63'b0, valid_M}, 64'd1);
        drain();
        check("alu_stall", 64'(stall_cnt - b_stall), 64'd0);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 64'h22, 64'h0, 64'h80, 1'b0);
        drain();
        check("alu_pcb_hold", PCBranch_M, 64'h80);

        // Load, ack in 3rd request cycle
        snap();
        ack_at = 3;
        rdata_val = 64'hDEAD;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h100, 64'h5555, 64'h0, 1'b0);
        drain();
        check("load_stall", 64'(stall_cnt - b_stall), 64'd2);
        check("load_req", 64'(req_cnt - b_req), 64'd3);
        check("load_valid", 64'(valid_cnt - b_valid), 64'd1);

        // Read and write both set: store wins, no data
        ack_at = 2;
        rdata_val = 64'h9999;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 64'h180, 64'h7777, 64'h0, 1'b0);
        drain();

        // Back-to-back stores, second accepted on the ack edge
        snap();
        ack_at = 1;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h200, 64'hAAAA, 64'h0, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 64'h208, 64'hBBBB, 64'h300, 1'b0);
        drain();
        check("b2b_req_rises", 64'(req_rises - b_rise), 64'd1);
        check("b2b_req", 64'(req_cnt - b_req), 64'd2);
        check("b2b_valid", 64'(valid_cnt - b_valid), 64'd2);

        // Load followed by ALU op accepted on its ack edge
        ack_at = 2;
        rdata_val = 64'hCAFE;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h400, 64'h0, 64'h0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 64'h44, 64'h0, 64'h500, 1'b0);
        drain();

        // Timeout abort, ALU op waiting behind it
        snap();
        ack_at = 0;
        rdata_val = 64'hF00D;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 64'h600, 64'h0, 64'h700, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 64'h66, 64'h0, 64'h77, 1'b0);
        drain();
        check("tmo_req", 64'(req_cnt - b_req), 64'd4);
        check("tmo_stall", 64'(stall_cnt - b_stall), 64'd4);
        check("tmo_idle_req", {63'b0, dm_req}, 64'd0);
        check("tmo_idle_state", {63'b0, dut.state}, {63'b0, S_IDLE});

        // Ack on the last allowed cycle wins over the timeout
        snap();
        ack_at = 4;
        rdata_val = 64'hBEEF;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h800, 64'h0, 64'h0, 1'b0);
        drain();
        check("late_ack_req", 64'(req_cnt - b_req), 64'd4);
        check("late_ack_stall", 64'(stall_cnt - b_stall), 64'd3);

        // Reset during the second BUSY cycle
        snap();
        ack_at = 0;
        begin
            req_t r;
            r.we = 1'b0;
            r.addr = 64'h900;
            r.wdata = 64'h0;
            rq.push_back(r);
        end
        valid_E     = 1'b1;
        MemRead_E   = 1'b1;
        aluResult_E = 64'h900;
        writeData_E = 64'h0;
        @(posedge clk);
        #2;
        idle_inputs();
        @(posedge clk);
        #2;
        check("mid_busy_req", {63'b0, dm_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {63'b0, dm_req}, 64'd0);
        check("mid_rst_stall", {63'b0, stall_M}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("mid_rst_valid", 64'(valid_cnt - b_valid), 64'd0);
        check("mid_rst_rq", 64'(rq.size()), 64'd0);

        // Fresh load after the reset
        ack_at = 2;
        rdata_val = 64'h1234;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h910, 64'h0, 64'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
